gray_a_bcd: RTL and testbench

- Upstream stage of bin_to_7segmentos_SubModulo.
- Captures an asynchronous Gray-coded word from switches/encoder, synchronises and filters it, then converts Gray→binary.
- Runs a sequential double-dabble (shift/add-3) to produce four BCD digits (unidad, decena, centena, milesima) for the display multiplexer.
- Raises a one-cycle `listo` strobe when new digits are valid.

---
 rtl/gray_a_bcd_pkg.sv | 27 ++
 rtl/gray_a_bcd_if.sv | 23 ++
 rtl/gray_a_bcd_sincronizador_2ff.sv | 24 ++
 rtl/gray_a_bcd.sv | 157 +++++++++++++++
 tb/tb_gray_a_bcd.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/gray_a_bcd_pkg.sv
// rtl/gray_a_bcd_pkg.sv - shared types, sizes and Gray decode for the gray_a_bcd front end
package gray_a_bcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CARGA,
    AJUSTE,
    DESPLAZA,
    FIN
  } estado_t;

  localparam int N_DIGITOS  = 4;
  localparam int ANCHO_BCD  = 4 * N_DIGITOS;
  localparam int MAX_N_BITS = 13;
  localparam int ANCHO_ITER = 4;

  // Zero-extended narrower words decode identically, so one width serves every N_BITS.
  function automatic logic [MAX_N_BITS-1:0] gray_a_bin(input logic [MAX_N_BITS-1:0] g);
    logic [MAX_N_BITS-1:0] b;
    b[MAX_N_BITS-1] = g[MAX_N_BITS-1];
    for (int i = MAX_N_BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_a_bcd_if.sv
// rtl/gray_a_bcd_if.sv - Gray input and BCD/status output bundle of gray_a_bcd
interface gray_a_bcd_if #(
  parameter int N_BITS = 4
);
  logic [N_BITS-1:0] gray_in;
  logic [N_BITS-1:0] bin_out;
  logic [3:0]        bcd_unidad;
  logic [3:0]        bcd_decena;
  logic [3:0]        bcd_centena;
  logic [3:0]        bcd_milesima;
  logic              listo;
  logic              ocupado;

  modport master (
    output gray_in,
    input  bin_out, bcd_unidad, bcd_decena, bcd_centena, bcd_milesima, listo, ocupado
  );

  modport slave (
    input  gray_in,
    output bin_out, bcd_unidad, bcd_decena, bcd_centena, bcd_milesima, listo, ocupado
  );
endinterface

// File: rtl/gray_a_bcd_sincronizador_2ff.sv
// rtl/gray_a_bcd_sincronizador_2ff.sv - two-flop synchroniser for any asynchronous input word
module sincronizador_2ff #(
  parameter int ANCHO = 1
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic [ANCHO-1:0] i_d,
  output logic [ANCHO-1:0] o_q
);
  logic [ANCHO-1:0] r_meta;
  logic [ANCHO-1:0] r_sync;

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/gray_a_bcd.sv
// rtl/gray_a_bcd.sv - Gray capture, Gray->binary and sequential double-dabble to four BCD digits
// Optional input debounce filter: GRAY_A_BCD_FILTRO_REBOTE_EN.
module gray_a_bcd
  import gray_a_bcd_pkg::*;
#(
  parameter int N_BITS          = 4,
  parameter int DEBOUNCE_CICLOS = 16
) (
  input  logic          reloj,
  input  logic          reset,
  gray_a_bcd_if.slave   bus
);

  if (N_BITS < 1 || N_BITS > MAX_N_BITS || DEBOUNCE_CICLOS < 1) begin : g_param_invalido
    $error("gray_a_bcd: parameters out of range");
  end

  logic [N_BITS-1:0]           w_g_sync;
  logic [MAX_N_BITS-1:0]       w_g_ext;
  logic [MAX_N_BITS-1:0]       w_bin_ext;
  logic [N_BITS-1:0]           w_bin;
  logic                        w_estable;
  logic                        w_inicio;
  estado_t                     r_estado;
  estado_t                     w_estado_sig;
  logic [N_BITS-1:0]           r_ultimo;
  logic [N_BITS-1:0]           r_bin_cap;
  logic [N_BITS-1:0]           r_shift;
  logic [ANCHO_BCD-1:0]        r_scratch;
  logic [ANCHO_BCD-1:0]        w_ajustado;
  logic [ANCHO_BCD+N_BITS-1:0] w_desplazado;
  logic [ANCHO_ITER-1:0]       r_iter;
  logic [N_BITS-1:0]           r_bin_out;
  logic [ANCHO_BCD-1:0]        r_bcd;

  sincronizador_2ff #(.ANCHO(N_BITS)) u_sinc (
    .reloj (reloj),
    .reset (reset),
    .i_d   (bus.gray_in),
    .o_q   (w_g_sync)
  );

`ifdef GRAY_A_BCD_FILTRO_REBOTE_EN
  localparam int ANCHO_CNT = $clog2(DEBOUNCE_CICLOS + 1);
  logic [N_BITS-1:0]    r_g_prev;
  logic [ANCHO_CNT-1:0] r_cnt_reb;

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_g_prev  <= '0;
      r_cnt_reb <= '0;
    end else begin
      r_g_prev <= w_g_sync;
      if (w_g_sync != r_g_prev) begin
        r_cnt_reb <= '0;
      end else if (r_cnt_reb != ANCHO_CNT'(DEBOUNCE_CICLOS)) begin
        r_cnt_reb <= r_cnt_reb + 1'b1;
      end
    end
  end

  assign w_estable = (r_cnt_reb >= ANCHO_CNT'(DEBOUNCE_CICLOS));
`else
  assign w_estable = 1'b1;
`endif

  always_comb begin
    w_g_ext             = '0;
    w_g_ext[N_BITS-1:0] = w_g_sync;
  end

  assign w_bin_ext = gray_a_bin(w_g_ext);
  assign w_bin     = w_bin_ext[N_BITS-1:0];
  assign w_inicio  = (r_estado == IDLE) && w_estable && (w_g_sync != r_ultimo);

  always_comb begin
    w_ajustado = r_scratch;
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_ajustado[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_desplazado = {r_scratch, r_shift} << 1;

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      IDLE:     if (w_inicio) w_estado_sig = CARGA;
      CARGA:    w_estado_sig = AJUSTE;
      AJUSTE:   w_estado_sig = DESPLAZA;
      DESPLAZA: w_estado_sig = (r_iter == ANCHO_ITER'(1)) ? FIN : AJUSTE;
      FIN:      w_estado_sig = IDLE;
      default:  w_estado_sig = IDLE;
    endcase
  end

  // The word is captured on the start decision so a change arriving in the same cycle cannot slip in.
  // Results load on the last shift so they are already valid while listo is high in FIN.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_ultimo  <= '0;
      r_bin_cap <= '0;
      r_shift   <= '0;
      r_scratch <= '0;
      r_iter    <= '0;
      r_bin_out <= '0;
      r_bcd     <= '0;
    end else begin
      case (r_estado)
        IDLE: begin
          if (w_inicio) begin
            r_ultimo  <= w_g_sync;
            r_bin_cap <= w_bin;
          end
        end
        CARGA: begin
          r_shift   <= r_bin_cap;
          r_scratch <= '0;
          r_iter    <= ANCHO_ITER'(N_BITS);
        end
        AJUSTE: begin
          r_scratch <= w_ajustado;
        end
        DESPLAZA: begin
          r_scratch <= w_desplazado[ANCHO_BCD+N_BITS-1:N_BITS];
          r_shift   <= w_desplazado[N_BITS-1:0];
          r_iter    <= r_iter - 1'b1;
          if (r_iter == ANCHO_ITER'(1)) begin
            r_bcd     <= w_desplazado[ANCHO_BCD+N_BITS-1:N_BITS];
            r_bin_out <= r_bin_cap;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.bin_out      = r_bin_out;
  assign bus.bcd_unidad   = r_bcd[3:0];
  assign bus.bcd_decena   = r_bcd[7:4];
  assign bus.bcd_centena  = r_bcd[11:8];
  assign bus.bcd_milesima = r_bcd[15:12];
  assign bus.listo        = (r_estado == FIN);
  assign bus.ocupado      = (r_estado != IDLE);

endmodule

// File: tb/tb_gray_a_bcd.sv
// tb/tb_gray_a_bcd.sv - scoreboard bench for gray_a_bcd with directed Gray vectors
module tb_gray_a_bcd;

  typedef struct packed {
    logic [3:0] bin;
    logic [3:0] u;
    logic [3:0] d;
    logic [3:0] c;
    logic [3:0] m;
  } esp_t;

  logic reloj;
  logic reset;
  esp_t q_esp[$];
  int   n_total;
  int   n_pass;
  int   n_listo;
  int   run_ocupado;
  logic prev_listo;

  gray_a_bcd_if #(.N_BITS(4)) u_if ();

  gray_a_bcd #(.N_BITS(4), .DEBOUNCE_CICLOS(16)) u_dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (u_if)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic chk(input bit ok, input string nombre, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", nombre, act, req);
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(posedge reloj);
    #1;
  endtask

  task automatic esperar_listo(input int objetivo);
    int k;
    k = 0;
    while (n_listo < objetivo && k < 400) begin
      ciclos(1);
      k++;
    end
    chk(n_listo >= objetivo, "listo_timeout", n_listo, objetivo);
    ciclos(3);
  endtask

  task automatic esperar_ocupado();
    int k;
    k = 0;
    while (!u_if.ocupado && k < 100) begin
      ciclos(1);
      k++;
    end
    chk(u_if.ocupado == 1'b1, "ocupado_timeout", int'(u_if.ocupado), 1);
  endtask

  task automatic empujar(input logic [3:0] b, input logic [3:0] un, input logic [3:0] de);
    esp_t e;
    e.bin = b; e.u = un; e.d = de; e.c = 4'd0; e.m = 4'd0;
    q_esp.push_back(e);
  endtask

  task automatic chk_ceros(input string etapa);
    chk(u_if.bin_out == 4'd0,      {etapa, "_bin_out"}, int'(u_if.bin_out), 0);
    chk(u_if.bcd_unidad == 4'd0,   {etapa, "_unidad"},  int'(u_if.bcd_unidad), 0);
    chk(u_if.bcd_decena == 4'd0,   {etapa, "_decena"},  int'(u_if.bcd_decena), 0);
    chk(u_if.listo == 1'b0,        {etapa, "_listo"},   int'(u_if.listo), 0);
    chk(u_if.ocupado == 1'b0,      {etapa, "_ocupado"}, int'(u_if.ocupado), 0);
  endtask

  always @(negedge reloj) begin
    esp_t e;
    if (reset) begin
      run_ocupado = 0;
      prev_listo  = 1'b0;
    end else begin
      if (u_if.listo) begin
        n_listo++;
        chk(!prev_listo, "listo_width", 2, 1);
        chk(u_if.ocupado == 1'b1, "ocupado_in_fin", int'(u_if.ocupado), 1);
        if (q_esp.size() == 0) begin
          chk(1'b0, "listo_extra", int'(u_if.bin_out), -1);
        end else begin
          e = q_esp.pop_front();
          chk(u_if.bin_out == e.bin,      "bin_out",      int'(u_if.bin_out),      int'(e.bin));
          chk(u_if.bcd_unidad == e.u,     "bcd_unidad",   int'(u_if.bcd_unidad),   int'(e.u));
          chk(u_if.bcd_decena == e.d,     "bcd_decena",   int'(u_if.bcd_decena),   int'(e.d));
          chk(u_if.bcd_centena == e.c,    "bcd_centena",  int'(u_if.bcd_centena),  int'(e.c));
          chk(u_if.bcd_milesima == e.m,   "bcd_milesima", int'(u_if.bcd_milesima), int'(e.m));
        end
      end
      if (u_if.ocupado) begin
        run_ocupado++;
      end else if (run_ocupado != 0) begin
        chk(run_ocupado == 10, "ocupado_len", run_ocupado, 10);
        run_ocupado = 0;
      end
      prev_listo = u_if.listo;
    end
  end

  initial begin
    int antes;
    n_total = 0; n_pass = 0; n_listo = 0; run_ocupado = 0; prev_listo = 1'b0;
    reset = 1'b1;
    u_if.gray_in = 4'b0110;
    repeat (5) @(posedge reloj);
    @(negedge reloj);
    chk_ceros("reset");

    // 0110 -> 4
    empujar(4'd4, 4'd4, 4'd0);
    ciclos(1);
    reset = 1'b0;
    esperar_listo(1);

    // 0001 -> 1
    empujar(4'd1, 4'd1, 4'd0);
    u_if.gray_in = 4'b0001;
    esperar_listo(2);

    // 1000 -> 15
    empujar(4'd15, 4'd5, 4'd1);
    u_if.gray_in = 4'b1000;
    esperar_listo(3);

`ifdef GRAY_A_BCD_FILTRO_REBOTE_EN
    antes = n_listo;
    for (int i = 0; i < 20; i++) begin
      u_if.gray_in = (i % 2 == 0) ? 4'b0010 : 4'b0011;
      ciclos(5);
    end
    chk(n_listo == antes, "listo_while_bouncing", n_listo, antes);
`endif
    // 0010 -> 3
    empujar(4'd3, 4'd3, 4'd0);
    u_if.gray_in = 4'b0010;
    esperar_listo(4);

    // 0001 then 0011 mid-conversion -> 1 then 2
    empujar(4'd1, 4'd1, 4'd0);
    u_if.gray_in = 4'b0001;
    esperar_ocupado();
    ciclos(3);
    empujar(4'd2, 4'd2, 4'd0);
    u_if.gray_in = 4'b0011;
    esperar_listo(6);

    // reset four cycles into a conversion of 1000
    antes = n_listo;
    u_if.gray_in = 4'b1000;
    esperar_ocupado();
    ciclos(3);
    @(posedge reloj);
    reset = 1'b1;
    #1;
    chk_ceros("abort");
    ciclos(3);
    chk(n_listo == antes, "listo_after_abort", n_listo, antes);
    empujar(4'd15, 4'd5, 4'd1);
    reset = 1'b0;
    esperar_listo(antes + 1);

    // stable zero after reset never converts
    reset = 1'b1;
    u_if.gray_in = 4'b0000;
    ciclos(3);
    reset = 1'b0;
    antes = n_listo;
    ciclos(60);
    chk(n_listo == antes, "zero_no_conversion", n_listo, antes);
    chk(u_if.bin_out == 4'd0, "zero_bin_out", int'(u_if.bin_out), 0);

    chk(q_esp.size() == 0, "scoreboard_empty", q_esp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
